channel_serializer: RTL and testbench

//   Width converter for Channels: accepts one NIN-bit word on in and emits it as K = ceil(NIN/NOUT)

---
 rtl/channel_serializer.sv | 104 ++++++++++
 tb/tb_channel_serializer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/channel_serializer.sv
// channel_serializer: splits one NIN-bit channel word into K = ceil(NIN/NOUT)
// NOUT-bit slices. The output slice is taken directly from a shift register,
// so there is no combinational path from in_d_i to out_d_o.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | no word held; out_v_o low, in_a_o follows in_v_i
// S_SEND | presenting slice idx_q; advances on out_a_i, reloads on last
module channel_serializer #(
   parameter int NIN       = 24,
   parameter int NOUT      = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic [NIN-1:0]  in_d_i,
   input  logic            in_v_i,
   output logic            in_a_o,
   output logic [NOUT-1:0] out_d_o,
   output logic            out_v_o,
   input  logic            out_a_i,
   output logic            last_o
);

   localparam int K    = (NIN + NOUT - 1) / NOUT;
   localparam int W    = K * NOUT;
   localparam int PAD  = W - NIN;
   localparam int LOGK = (K > 1) ? $clog2(K) : 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

   localparam logic [LOGK-1:0] IDX_LAST = LOGK'(K - 1);

   logic [0:0]      state_q, state_d;
   logic [LOGK-1:0] idx_q,   idx_d;
   logic [W-1:0]    shreg_q, shreg_d;

   logic [W-1:0]    padded;
   logic [W-1:0]    shifted;
   logic            at_last;

   // Zero padding lands on the side that is emitted last, so the word's
   // meaningful bits always lead the slice stream.
   assign padded  = MSB_FIRST ? (W'(in_d_i) << PAD) : W'(in_d_i);
   assign shifted = MSB_FIRST ? (shreg_q << NOUT) : (shreg_q >> NOUT);
   assign at_last = (idx_q == IDX_LAST);

   // Next-state, shift and acknowledge logic.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      shreg_d = shreg_q;
      in_a_o  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (in_v_i) begin
               in_a_o  = 1'b1;
               shreg_d = padded;
               idx_d   = '0;
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            if (out_a_i) begin
               if (!at_last) begin
                  idx_d   = idx_q + LOGK'(1);
                  shreg_d = shifted;
               end else if (in_v_i) begin
                  // Back-to-back reload: next word's first slice follows
                  // the current word's last slice with no bubble.
                  in_a_o  = 1'b1;
                  shreg_d = padded;
                  idx_d   = '0;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            idx_d   = '0;
         end
      endcase
   end

   // State registers; reset discards any word in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         shreg_q <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         shreg_q <= shreg_d;
      end
   end

   assign out_d_o = MSB_FIRST ? shreg_q[W-1 -: NOUT] : shreg_q[NOUT-1:0];
   assign out_v_o = (state_q == S_SEND);
   assign last_o  = out_v_o & at_last;

endmodule

// File: tb/tb_channel_serializer.sv
// Testbench for channel_serializer: directed scenarios plus randomized
// traffic checked against a slice-queue reference model.
module tb_channel_serializer;

   logic        clk = 1'b0;
   logic        reset_n;

   // 24-bit / 8-bit, MSB first
   logic [23:0] in_d;
   logic        in_v, in_a, out_v, out_a, last;
   logic [7:0]  out_d;

   // 20-bit / 8-bit, both orders, shared inputs
   logic [19:0] b_d;
   logic        b_v, b_a;
   logic        m_ina, m_v, m_last, l_ina, l_v, l_last;
   logic [7:0]  m_d, l_d;

   int checks = 0;
   int fails  = 0;

   always #5 clk = ~clk;

   channel_serializer #(.NIN(24), .NOUT(8), .MSB_FIRST(1'b1)) dut0 (
      .clk(clk), .reset_n(reset_n),
      .in_d_i(in_d), .in_v_i(in_v), .in_a_o(in_a),
      .out_d_o(out_d), .out_v_o(out_v), .out_a_i(out_a), .last_o(last));

   channel_serializer #(.NIN(20), .NOUT(8), .MSB_FIRST(1'b1)) dut_m (
      .clk(clk), .reset_n(reset_n),
      .in_d_i(b_d), .in_v_i(b_v), .in_a_o(m_ina),
      .out_d_o(m_d), .out_v_o(m_v), .out_a_i(b_a), .last_o(m_last));

   channel_serializer #(.NIN(20), .NOUT(8), .MSB_FIRST(1'b0)) dut_l (
      .clk(clk), .reset_n(reset_n),
      .in_d_i(b_d), .in_v_i(b_v), .in_a_o(l_ina),
      .out_d_o(l_d), .out_v_o(l_v), .out_a_i(b_a), .last_o(l_last));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive dut0 inputs at the falling edge, then settle before sampling.
   task automatic drive(input logic v, input logic [23:0] d, input logic a);
      @(negedge clk);
      in_v  = v;
      in_d  = d;
      out_a = a;
      #1;
   endtask

   task automatic expect_out(input string tag, input logic v, input logic [7:0] d,
                             input logic l);
      chk({tag, "_v"}, 32'(out_v), 32'(v));
      if (v) chk({tag, "_d"}, 32'(out_d), 32'(d));
      chk({tag, "_last"}, 32'(last), 32'(l));
   endtask

   // Reference model: expected slice stream and last flags.
   logic [7:0] exp_q[$];
   logic       exp_last_q[$];
   int         acc, lasts, cyc;
   logic       prev_stall;
   logic [7:0] prev_d;

   function automatic logic [7:0] slice24(input logic [23:0] w, input int i);
      return 8'((w >> ((2 - i) * 8)) & 24'hFF);
   endfunction

   task automatic rnd_cycle(input bit allow_v);
      logic [7:0] e;
      logic       el;
      @(negedge clk);
      cyc++;
      in_v  = allow_v && ($urandom_range(0, 9) < 7);
      in_d  = 24'($urandom);
      out_a = ($urandom_range(0, 9) < 7);
      #1;
      if (prev_stall) begin
         chk("hold_v", 32'(out_v), 32'd1);
         chk("hold_d", 32'(out_d), 32'(prev_d));
      end
      if (!in_v) chk("ina_without_v", 32'(in_a), 32'd0);
      if (in_v && in_a) begin
         acc++;
         for (int i = 0; i < 3; i++) begin
            exp_q.push_back(slice24(in_d, i));
            exp_last_q.push_back(i == 2);
         end
      end
      if (out_v && out_a) begin
         chk("slice_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e  = exp_q.pop_front();
            el = exp_last_q.pop_front();
            chk("rnd_d", 32'(out_d), 32'(e));
            chk("rnd_last", 32'(last), 32'(el));
         end
         if (last) lasts++;
      end
      prev_stall = out_v && !out_a;
      prev_d     = out_d;
   endtask

   initial begin
      reset_n = 1'b0;
      in_v = 1'b0; in_d = '0; out_a = 1'b0;
      b_v = 1'b0; b_d = '0; b_a = 1'b1;
      #1;
      expect_out("reset", 1'b0, 8'h00, 1'b0);
      chk("reset_d", 32'(out_d), 32'd0);
      chk("reset_ina", 32'(in_a), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Single word, out_a tied high
      drive(1'b1, 24'hA1B2C3, 1'b1);
      chk("t1_accept", 32'(in_a), 32'd1);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t1_a1", 1'b1, 8'hA1, 1'b0);
      chk("t1_ina0", 32'(in_a), 32'd0);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t1_b2", 1'b1, 8'hB2, 1'b0);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t1_c3", 1'b1, 8'hC3, 1'b1);
      chk("t1_ina_c3", 32'(in_a), 32'd0);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t1_idle", 1'b0, 8'h00, 1'b0);

      // Two words back to back
      drive(1'b1, 24'h112233, 1'b1);
      chk("t2_accept1", 32'(in_a), 32'd1);
      drive(1'b1, 24'h445566, 1'b1);
      expect_out("t2_11", 1'b1, 8'h11, 1'b0);
      chk("t2_ina_11", 32'(in_a), 32'd0);
      drive(1'b1, 24'h445566, 1'b1);
      expect_out("t2_22", 1'b1, 8'h22, 1'b0);
      chk("t2_ina_22", 32'(in_a), 32'd0);
      drive(1'b1, 24'h445566, 1'b1);
      expect_out("t2_33", 1'b1, 8'h33, 1'b1);
      chk("t2_accept2", 32'(in_a), 32'd1);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t2_44", 1'b1, 8'h44, 1'b0);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t2_55", 1'b1, 8'h55, 1'b0);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t2_66", 1'b1, 8'h66, 1'b1);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t2_idle", 1'b0, 8'h00, 1'b0);

      // Backpressure on the middle slice; in_d changes are ignored
      drive(1'b1, 24'hA1B2C3, 1'b1);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t3_a1", 1'b1, 8'hA1, 1'b0);
      for (int i = 0; i < 5; i++) begin
         drive(1'b1, 24'($urandom), 1'b0);
         expect_out("t3_stall", 1'b1, 8'hB2, 1'b0);
         chk("t3_stall_ina", 32'(in_a), 32'd0);
      end
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t3_b2", 1'b1, 8'hB2, 1'b0);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t3_c3", 1'b1, 8'hC3, 1'b1);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t3_idle", 1'b0, 8'h00, 1'b0);

      // 20-bit padding in both slice orders
      @(negedge clk);
      b_v = 1'b1; b_d = 20'hABCDE; b_a = 1'b1;
      #1;
      chk("t4_m_accept", 32'(m_ina), 32'd1);
      chk("t4_l_accept", 32'(l_ina), 32'd1);
      @(negedge clk);
      b_v = 1'b0;
      #1;
      chk("t4_m0", 32'({m_v, m_d, m_last}), 32'({1'b1, 8'hAB, 1'b0}));
      chk("t4_l0", 32'({l_v, l_d, l_last}), 32'({1'b1, 8'hDE, 1'b0}));
      @(negedge clk);
      #1;
      chk("t4_m1", 32'({m_v, m_d, m_last}), 32'({1'b1, 8'hCD, 1'b0}));
      chk("t4_l1", 32'({l_v, l_d, l_last}), 32'({1'b1, 8'hBC, 1'b0}));
      @(negedge clk);
      #1;
      chk("t4_m2", 32'({m_v, m_d, m_last}), 32'({1'b1, 8'hE0, 1'b1}));
      chk("t4_l2", 32'({l_v, l_d, l_last}), 32'({1'b1, 8'h0A, 1'b1}));
      @(negedge clk);
      #1;
      chk("t4_m_idle", 32'(m_v), 32'd0);
      chk("t4_l_idle", 32'(l_v), 32'd0);

      // Asynchronous reset mid-word
      drive(1'b1, 24'hA1B2C3, 1'b1);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t5_a1", 1'b1, 8'hA1, 1'b0);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t5_b2", 1'b1, 8'hB2, 1'b0);
      #1 reset_n = 1'b0;
      #1;
      expect_out("t5_rst", 1'b0, 8'h00, 1'b0);
      chk("t5_rst_d", 32'(out_d), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 24'h0, 1'b1);
         expect_out("t5_no_c3", 1'b0, 8'h00, 1'b0);
      end
      drive(1'b1, 24'h010203, 1'b1);
      chk("t5_accept", 32'(in_a), 32'd1);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t5_01", 1'b1, 8'h01, 1'b0);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t5_02", 1'b1, 8'h02, 1'b0);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t5_03", 1'b1, 8'h03, 1'b1);
      drive(1'b0, 24'h0, 1'b1);
      expect_out("t5_idle", 1'b0, 8'h00, 1'b0);

      // Randomized traffic against the slice-queue model
      acc = 0; lasts = 0; cyc = 0; prev_stall = 1'b0; prev_d = '0;
      while (acc < 1000 && cyc < 20000) rnd_cycle(1'b1);
      while (exp_q.size() != 0 && cyc < 20100) rnd_cycle(1'b0);
      chk("rnd_budget", 32'(cyc < 20100 && acc == 1000), 32'd1);
      chk("rnd_drained", 32'(exp_q.size()), 32'd0);
      chk("rnd_last_count", 32'(lasts), 32'(acc));
      drive(1'b0, 24'h0, 1'b1);
      chk("rnd_idle", 32'(out_v), 32'd0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
